// File: rtl/dwa_dem_encoder.sv
// DWA dynamic element matching encoder: clamps a quantizer code, builds a thermometer
// mask and rotates it from a running pointer; one register stage on every output.
module dwa_dem_encoder #(
  parameter int unsigned CODE_WIDTH   = 3,
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CODE_WIDTH-1:0]   code_i,
  input  logic                    code_valid_i,
  input  logic                    dem_en_i,
  output logic [NUM_ELEMENTS-1:0] elem_sel_o,
  output logic                    sel_valid_o,
  output logic [PTR_WIDTH-1:0]    ptr_o,
  output logic                    ovf_o
);

  localparam int unsigned SUM_W = PTR_WIDTH + 1;
  localparam int unsigned K_W   = (CODE_WIDTH > SUM_W) ? CODE_WIDTH : SUM_W;
  localparam logic [K_W-1:0]   N_K = K_W'(NUM_ELEMENTS);
  localparam logic [SUM_W-1:0] N_S = SUM_W'(NUM_ELEMENTS);

  logic [NUM_ELEMENTS-1:0] sel_q, sel_d;
  logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;

  logic [K_W-1:0]          code_ext_c;
  logic [K_W-1:0]          k_c;
  logic                    ovf_c;
  logic [SUM_W-1:0]        ptr_ext_c;
  logic [SUM_W-1:0]        sum_c;
  logic [SUM_W-1:0]        ptr_nxt_c;
  logic [NUM_ELEMENTS-1:0] therm_c;
  logic [NUM_ELEMENTS-1:0] rot_c;

  // Clamp the code to the number of available elements.
  assign code_ext_c = K_W'(code_i);
  assign ovf_c      = (code_ext_c > N_K);
  assign k_c        = ovf_c ? N_K : code_ext_c;

  // Pointer advance: one conditional subtract keeps non-power-of-two sizes exact.
  assign ptr_ext_c  = SUM_W'(ptr_q);
  assign sum_c      = ptr_ext_c + SUM_W'(k_c);
  assign ptr_nxt_c  = (sum_c >= N_S) ? (sum_c - N_S) : sum_c;

  // Element i is enabled when its distance past the pointer (mod N) is below k.
  for (genvar gi = 0; gi < int'(NUM_ELEMENTS); gi++) begin : g_elem
    localparam logic [SUM_W-1:0] IDX = SUM_W'(gi);
    logic [SUM_W-1:0] off_c;
    assign off_c       = (IDX >= ptr_ext_c) ? (IDX - ptr_ext_c) : (IDX + N_S - ptr_ext_c);
    assign therm_c[gi] = (K_W'(IDX) < k_c);
    assign rot_c[gi]   = (K_W'(off_c) < k_c);
  end

  always_comb begin
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (code_valid_i) begin
      valid_d = 1'b1;
      ovf_d   = ovf_c;
      if (dem_en_i) begin
        sel_d = rot_c;
        ptr_d = PTR_WIDTH'(ptr_nxt_c);
      end else begin
        sel_d = therm_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign elem_sel_o  = sel_q;
  assign ptr_o       = ptr_q;
  assign sel_valid_o = valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dwa_dem_encoder.sv
// Scoreboard bench for dwa_dem_encoder: an 8-element/4-bit-code instance and a
// 5-element/3-bit-code instance share stimulus; a reference model feeds per-instance queues.
module tb_dwa_dem_encoder;

  typedef struct packed {
    logic [7:0] sel;
    logic [2:0] ptr;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code = '0;
  logic       valid = 1'b0;
  logic       dem = 1'b1;

  logic [7:0] sel0;
  logic [4:0] sel1;
  logic [2:0] ptr0, ptr1;
  logic       v0, v1, ovf0, ovf1;

  int   checks = 0;
  int   errors = 0;
  int   p0 = 0, p1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t hold0 = '0, hold1 = '0;
  bit   rst_seen;

  always #5 clk = ~clk;

  dwa_dem_encoder #(.CODE_WIDTH(4), .NUM_ELEMENTS(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .code_i(code), .code_valid_i(valid), .dem_en_i(dem),
    .elem_sel_o(sel0), .sel_valid_o(v0), .ptr_o(ptr0), .ovf_o(ovf0)
  );

  dwa_dem_encoder #(.CODE_WIDTH(3), .NUM_ELEMENTS(5)) dut1 (
    .clk_i(clk), .rst_i(rst), .code_i(code[2:0]), .code_valid_i(valid), .dem_en_i(dem),
    .elem_sel_o(sel1), .sel_valid_o(v1), .ptr_o(ptr1), .ovf_o(ovf1)
  );

  // Reference: k = min(code, n); DWA sets positions p..p+k-1 mod n, bypass sets 0..k-1.
  task automatic model(input int n, input int c, input bit d, inout int p, output exp_t e);
    int k;
    e     = '0;
    k     = (c > n) ? n : c;
    e.ovf = (c > n);
    for (int j = 0; j < k; j++) begin
      if (d) e.sel = e.sel | (8'd1 << ((p + j) % n));
      else   e.sel = e.sel | (8'd1 << j);
    end
    if (d) p = (p + k) % n;
    e.ptr = 3'(p);
  endtask

  task automatic cmp(input string name, input int inst, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, inst, $time, got, want);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit d, input logic [3:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; valid = v; dem = d; code = c;
    if (r) begin
      p0 = 0; p1 = 0;
    end else if (v) begin
      model(8, int'(c), d, p0, e);
      q0.push_back(e);
      model(5, int'(c[2:0]), d, p1, e);
      q1.push_back(e);
    end
  endtask

  task automatic check_inst(input int inst, input logic vld, input logic [7:0] s,
                            input logic [2:0] p, input logic o);
    exp_t e;
    if (rst_seen) begin
      e = '0;
      cmp("rst_valid", inst, int'(vld), 0);
    end else if (vld) begin
      if (inst == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (inst == 1 && q1.size() > 0) e = q1.pop_front();
      else begin
        cmp("unexpected_valid", inst, 1, 0);
        return;
      end
    end else begin
      e = (inst == 0) ? hold0 : hold1;
    end
    cmp(vld ? "elem_sel" : "hold_sel", inst, int'(s), int'(e.sel));
    cmp(vld ? "ptr" : "hold_ptr", inst, int'(p), int'(e.ptr));
    cmp(vld ? "ovf" : "hold_ovf", inst, int'(o), int'(e.ovf));
    if (inst == 0) hold0 = e;
    else           hold1 = e;
  endtask

  // Monitor: note reset at the edge, then compare outputs on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      rst_seen = rst;
      @(negedge clk);
      check_inst(0, v0, sel0, ptr0, ovf0);
      check_inst(1, v1, {3'b000, sel1}, ptr1, ovf1);
    end
  end

  initial begin
    drive(1, 0, 1, 4'd0);
    drive(1, 0, 1, 4'd0);
    // rotation and wrap
    drive(0, 1, 1, 4'd3);
    drive(0, 1, 1, 4'd3);
    drive(0, 1, 1, 4'd3);
    // extremes
    drive(0, 1, 1, 4'd0);
    drive(0, 1, 1, 4'd7);
    // bypass from ptr 5, then resume
    drive(0, 1, 1, 4'd5);
    drive(0, 1, 0, 4'd5);
    drive(0, 1, 1, 4'd2);
    // hold
    drive(0, 1, 1, 4'd4);
    repeat (3) drive(0, 0, 1, 4'd9);
    // reset mid-stream at ptr 6 with a valid code
    drive(0, 1, 1, 4'd3);
    drive(1, 1, 1, 4'd3);
    drive(0, 1, 1, 4'd2);
    // overflow from ptr 3
    drive(0, 1, 1, 4'd1);
    drive(0, 1, 1, 4'd12);
    drive(0, 1, 1, 4'd1);
    drive(0, 0, 1, 4'd0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)));
    end
    drive(0, 0, 1, 4'd0);
    repeat (3) @(negedge clk);
    cmp("q0_drained", 0, q0.size(), 0);
    cmp("q1_drained", 1, q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwa_dem_encoder.md
# dwa_dem_encoder

Data-weighted-averaging (DWA) dynamic element matching encoder. It sits directly downstream of the multi-bit quantizer in the DEM-DAC path. Each accepted quantizer code k is converted into a one-hot-per-element selection vector that enables k unit DAC elements. The enabled elements start at a rotating pointer, so element mismatch is first-order noise-shaped.

## Interface
Parameters:
- CODE_WIDTH, 3: width of the quantizer code input.
- NUM_ELEMENTS, 8: number of unit DAC elements; must be ≥ 2 and ≤ 2**CODE_WIDTH.
- PTR_WIDTH, $clog2(NUM_ELEMENTS): width of the rotation pointer.

Ports:
- clk_i, input, 1: system clock, rising-edge active.
- rst_i, input, 1: reset, synchronous, active-high.
- code_i, input, CODE_WIDTH: unsigned quantizer code (number of elements to enable).
- code_valid_i, input, 1: code_i is valid this cycle; the sample is accepted at the clock edge.
- dem_en_i, input, 1: 1 = DWA rotation; 0 = static thermometer bypass.
- elem_sel_o, output, NUM_ELEMENTS: unit-element enables; bit i drives element i.
- sel_valid_o, output, 1: elem_sel_o was updated by the sample accepted on the previous edge.
- ptr_o, output, PTR_WIDTH: current rotation pointer, i.e. the start index for the next sample.
- ovf_o, output, 1: the last accepted code exceeded NUM_ELEMENTS and was clamped.

## Operation
- Clock and reset:
  - One clock: clk_i.
  - Reset is synchronous and active-high on rst_i.
- Reset values: elem_sel_o = 0, sel_valid_o = 0, ptr_o = 0, ovf_o = 0.
- Clamping:
  - k = min(code_i, NUM_ELEMENTS).
  - ovf_o = (code_i > NUM_ELEMENTS); it updates only on accepted samples.
- DWA mode (dem_en_i = 1), on an accepted sample with pointer p:
  - Set bits (p + j) mod NUM_ELEMENTS for j = 0..k-1; all other bits are 0.
  - Next pointer p' = (p + k) mod NUM_ELEMENTS.
  - Wrap-around applies to both the selection and the pointer.
  - k = 0 gives all-zero selection and leaves the pointer unchanged.
  - k = NUM_ELEMENTS gives all ones and leaves the pointer unchanged.
- Bypass mode (dem_en_i = 0), on an accepted sample:
  - elem_sel_o = thermometer code with bits 0..k-1 set.
  - Pointer is held, not reset; DWA resumes from the held value when dem_en_i returns to 1.
- dem_en_i is sampled with the code on the accepting edge. Mode changes therefore take effect per sample, with no glitch to elem_sel_o between samples.
- No sample (code_valid_i = 0):
  - elem_sel_o and ovf_o hold their last values (DAC hold).
  - ptr_o holds.
  - sel_valid_o = 0.
- Modulo arithmetic:
  - Compute the pointer sum in PTR_WIDTH+1 bits, then subtract NUM_ELEMENTS once if the sum ≥ NUM_ELEMENTS.
  - Must be correct for non-power-of-two NUM_ELEMENTS.
- Internal state is only the pointer, the output registers and the valid flag; there is no FSM beyond this.
- Structure: one combinational rotate/mask stage feeding one register stage. It is suitable for a barrel-rotated thermometer implementation.

## Timing
- Latency: exactly 1 cycle. A code accepted at edge n appears on elem_sel_o after edge n, with sel_valid_o = 1 for that cycle.
- Throughput: one code per cycle; back-to-back valid cycles are fully supported.
- ptr_o updates on the same edge as elem_sel_o and shows p'.
- Reset priority:
  - rst_i = 1 at an edge overrides code_valid_i.
  - All outputs take their reset values at that edge, and the sample is discarded.
  - The first sample after reset deasserts starts at pointer 0.
- Reset mid-stream: the pointer returns to 0; no partial selection is retained.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Test plan
All scenarios use NUM_ELEMENTS = 8 and CODE_WIDTH = 3 unless noted.
- Rotation and wrap:
  - After reset, dem_en=1, valid codes 3,3,3 back-to-back.
  - Expect elem_sel 00000111, 00111000, 11000001 on consecutive cycles.
  - Expect ptr_o 3, 6, 1.
  - Expect sel_valid high for 3 cycles.
- Extremes:
  - From ptr 1, code 0 -> elem_sel 00000000, ptr stays 1.
  - Then code 7 -> elem_sel 11111110, ptr 0.
- Bypass:
  - ptr = 5, dem_en=0, code 5 -> elem_sel 00011111, ptr_o stays 5.
  - Then dem_en=1, code 2 -> elem_sel 01100000, ptr 7.
- Hold:
  - Valid code 4, then 3 idle cycles.
  - Expect elem_sel held at the code-4 pattern and ptr held.
  - Expect sel_valid = 1 only in the first cycle.
- Reset mid-stream:
  - ptr = 6; assert rst_i together with valid code 3.
  - Next cycle: elem_sel 0, sel_valid 0, ptr 0.
  - After release, code 2 -> 00000011.
- Overflow (CODE_WIDTH=4, NUM_ELEMENTS=8):
  - code 12 from ptr 3 -> elem_sel 11111111, ovf_o 1, ptr 3.
  - Next code 1 -> 00001000, ovf_o 0.
